// File: rtl/conv_load_sequencer.sv
// Load/convolve sequencer: streams filter and input vectors into the F and X memories,
// then holds conv_start for one pass. Optional macro FILTER_REUSE_EN keeps the filter loaded.
module conv_load_sequencer #(
  parameter int unsigned DATA_W           = 8,
  parameter int unsigned X_MEM_SIZE       = 8,
  parameter int unsigned F_MEM_SIZE       = 4,
  parameter int unsigned X_MEM_ADDR_WIDTH = 3,
  parameter int unsigned F_MEM_ADDR_WIDTH = 2,
  parameter int unsigned CNT_W            = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           s_data_in_x,
  input  logic                        s_valid_x,
  output logic                        s_ready_x,
  input  logic [DATA_W-1:0]           s_data_in_f,
  input  logic                        s_valid_f,
  output logic                        s_ready_f,
  output logic                        wr_en_x,
  output logic [X_MEM_ADDR_WIDTH-1:0] wr_addr_x,
  output logic [DATA_W-1:0]           wr_data_x,
  output logic                        wr_en_f,
  output logic [F_MEM_ADDR_WIDTH-1:0] wr_addr_f,
  output logic [DATA_W-1:0]           wr_data_f,
  input  logic                        conv_done,
  output logic                        conv_start,
  output logic                        busy,
  output logic [CNT_W-1:0]            pass_cnt
);

  typedef enum logic [1:0] {StLoad, StConv, StFlush} state_e;

  localparam logic [X_MEM_ADDR_WIDTH-1:0] XLast = X_MEM_ADDR_WIDTH'(X_MEM_SIZE - 1);
  localparam logic [F_MEM_ADDR_WIDTH-1:0] FLast = F_MEM_ADDR_WIDTH'(F_MEM_SIZE - 1);

  state_e                        state_q, state_d;
  logic [X_MEM_ADDR_WIDTH-1:0]   x_cnt_q, x_cnt_d;
  logic [F_MEM_ADDR_WIDTH-1:0]   f_cnt_q, f_cnt_d;
  logic                          x_full_q, x_full_d;
  logic                          f_full_q, f_full_d;
  logic                          conv_start_q, conv_start_d;
  logic [CNT_W-1:0]              pass_cnt_q, pass_cnt_d;
  logic                          x_fire, f_fire;

  // Stream handshake and memory write port; readies are forced low while reset is sampled.
  always_comb begin
    s_ready_x  = !reset && (state_q == StLoad) && !x_full_q;
    s_ready_f  = !reset && (state_q == StLoad) && !f_full_q;
    x_fire     = s_valid_x && s_ready_x;
    f_fire     = s_valid_f && s_ready_f;
    wr_en_x    = x_fire;
    wr_addr_x  = x_cnt_q;
    wr_data_x  = s_data_in_x;
    wr_en_f    = f_fire;
    wr_addr_f  = f_cnt_q;
    wr_data_f  = s_data_in_f;
    conv_start = conv_start_q;
    busy       = !reset && (state_q != StLoad);
    pass_cnt   = pass_cnt_q;
  end

  always_comb begin
    state_d      = state_q;
    x_cnt_d      = x_cnt_q;
    f_cnt_d      = f_cnt_q;
    x_full_d     = x_full_q;
    f_full_d     = f_full_q;
    conv_start_d = conv_start_q;
    pass_cnt_d   = pass_cnt_q;

    unique case (state_q)
      StLoad: begin
        if (x_fire) begin
          if (x_cnt_q == XLast) begin
            x_cnt_d  = '0;
            x_full_d = 1'b1;
          end else begin
            x_cnt_d = x_cnt_q + 1'b1;
          end
        end
        if (f_fire) begin
          if (f_cnt_q == FLast) begin
            f_cnt_d  = '0;
            f_full_d = 1'b1;
          end else begin
            f_cnt_d = f_cnt_q + 1'b1;
          end
        end
        // Both flags were set on an earlier edge, so the last beat is already in memory.
        if (x_full_q && f_full_q) begin
          state_d      = StConv;
          conv_start_d = 1'b1;
        end
      end
      StConv: begin
        if (conv_done) begin
          state_d      = StFlush;
          conv_start_d = 1'b0;
          x_full_d     = 1'b0;
          if (!(&pass_cnt_q)) begin
            pass_cnt_d = pass_cnt_q + 1'b1;
          end
`ifdef FILTER_REUSE_EN
          f_full_d = f_full_q;
`else
          f_full_d = 1'b0;
`endif
        end
      end
      StFlush: begin
        state_d = StLoad;
      end
      default: begin
        state_d      = StLoad;
        conv_start_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StLoad;
      x_cnt_q      <= '0;
      f_cnt_q      <= '0;
      x_full_q     <= 1'b0;
      f_full_q     <= 1'b0;
      conv_start_q <= 1'b0;
      pass_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      x_cnt_q      <= x_cnt_d;
      f_cnt_q      <= f_cnt_d;
      x_full_q     <= x_full_d;
      f_full_q     <= f_full_d;
      conv_start_q <= conv_start_d;
      pass_cnt_q   <= pass_cnt_d;
    end
  end

endmodule

// File: tb/tb_conv_load_sequencer.sv
// Directed bench for conv_load_sequencer: per-cycle vector table plus multi-pass sequences.
module tb_conv_load_sequencer;

`ifdef FILTER_REUSE_EN
  localparam bit Reuse = 1'b1;
`else
  localparam bit Reuse = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] s_data_in_x, s_data_in_f;
  logic       s_valid_x, s_valid_f, s_ready_x, s_ready_f;
  logic       wr_en_x, wr_en_f;
  logic [2:0] wr_addr_x;
  logic [1:0] wr_addr_f;
  logic [7:0] wr_data_x, wr_data_f;
  logic       conv_done, conv_start, busy;
  logic [15:0] pass_cnt;

  conv_load_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .s_data_in_x(s_data_in_x),
    .s_valid_x  (s_valid_x),
    .s_ready_x  (s_ready_x),
    .s_data_in_f(s_data_in_f),
    .s_valid_f  (s_valid_f),
    .s_ready_f  (s_ready_f),
    .wr_en_x    (wr_en_x),
    .wr_addr_x  (wr_addr_x),
    .wr_data_x  (wr_data_x),
    .wr_en_f    (wr_en_f),
    .wr_addr_f  (wr_addr_f),
    .wr_data_f  (wr_data_f),
    .conv_done  (conv_done),
    .conv_start (conv_start),
    .busy       (busy),
    .pass_cnt   (pass_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected bundle: {rdy_x, rdy_f, wen_x, addr_x, wen_f, addr_f, start, busy, pass_cnt, dx, df}
  typedef struct {
    logic        rst;
    logic        vx;
    logic [7:0]  dx;
    logic        vf;
    logic [7:0]  df;
    logic        done;
    logic [42:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic add(input logic rst, input logic vx, input int dx, input logic vf, input int df,
                     input logic done, input logic rx, input logic rf, input logic wx,
                     input int ax, input logic wf, input int af, input logic cs,
                     input logic bsy, input int pc);
    vec_t v;
    v.rst  = rst;
    v.vx   = vx;
    v.dx   = 8'(dx);
    v.vf   = vf;
    v.df   = 8'(df);
    v.done = done;
    v.exp  = {rx, rf, wx, 3'(ax), wf, 2'(af), cs, bsy, 16'(pc), 8'(dx), 8'(df)};
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams one pass (8 X, 4 F beats offered) and stops once conv_start is seen.
  task automatic run_pass(output int lat, output int xs, output int fs, output bit f_rdy_seen);
    xs = 0;
    fs = 0;
    lat = -1;
    f_rdy_seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      s_valid_x   = (xs < 8);
      s_data_in_x = 8'(50 + xs);
      s_valid_f   = (fs < 4);
      s_data_in_f = 8'(60 + fs);
      @(negedge clk);
      if (conv_start) lat = n;
      if (s_ready_f) f_rdy_seen = 1'b1;
      if (wr_en_x) xs++;
      if (wr_en_f) fs++;
      step();
      if (lat >= 0) break;
    end
    s_valid_x = 1'b0;
    s_valid_f = 1'b0;
  endtask

  task automatic pulse_done();
    conv_done = 1'b1;
    @(negedge clk);
    step();
    conv_done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, xs, fs;
    bit f_rdy_seen;
    logic [42:0] act;

    reset = 1'b1;
    s_valid_x = 1'b0;
    s_valid_f = 1'b0;
    s_data_in_x = '0;
    s_data_in_f = '0;
    conv_done = 1'b0;

    // Pass 1: both streams with valid held high
    add(0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 1, 10 + k, 1, k + 1, 0,  1, 1, 1, k, 1, k, 0, 0, 0);
    for (int k = 4; k < 8; k++) add(0, 1, 10 + k, 1, 9, 0,  1, 0, 1, k, 0, 0, 0, 0, 0);
    add(0, 1, 18, 1, 9, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) add(0, 1, 18, 1, 9, 0,  0, 0, 0, 0, 0, 0, 1, 1, 0);
    add(0, 1, 18, 1, 9, 1,  0, 0, 0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0,  1, !Reuse, 0, 0, 0, 0, 0, 0, 1);
    // conv_done in LOAD is ignored
    add(0, 0, 0, 0, 0, 1,  1, !Reuse, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,  1, !Reuse, 0, 0, 0, 0, 0, 0, 1);
    // Pass 2: X stalls after 3 beats while F finishes
    for (int j = 0; j < 3; j++)
      add(0, 1, 20 + j, 1, 5 + j, 0,  1, !Reuse, 1, j, !Reuse, Reuse ? 0 : j, 0, 0, 1);
    add(0, 0, 0, 1, 8, 0,  1, !Reuse, 0, 3, !Reuse, Reuse ? 0 : 3, 0, 0, 1);
    add(0, 0, 0, 1, 8, 0,  1, 0, 0, 3, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,  1, 0, 0, 3, 0, 0, 0, 0, 1);
    for (int j = 3; j < 8; j++) add(0, 1, 20 + j, 0, 0, 0,  1, 0, 1, j, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1, 1);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1, 1);
    // Reset mid-CONV, then reload from address 0
    add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 30, 1, 40, 0,  1, 1, 1, 0, 1, 0, 0, 0, 0);
    add(0, 1, 31, 1, 41, 0,  1, 1, 1, 1, 1, 1, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      reset       = tbl[i].rst;
      s_valid_x   = tbl[i].vx;
      s_data_in_x = tbl[i].dx;
      s_valid_f   = tbl[i].vf;
      s_data_in_f = tbl[i].df;
      conv_done   = tbl[i].done;
      @(negedge clk);
      act = {s_ready_x, s_ready_f, wr_en_x, wr_addr_x, wr_en_f, wr_addr_f, conv_start, busy,
             pass_cnt, wr_data_x, wr_data_f};
      check($sformatf("vec%0d", i), 64'(act), 64'(tbl[i].exp));
      step();
    end
    reset = 1'b0;
    s_valid_x = 1'b0;
    s_valid_f = 1'b0;
    conv_done = 1'b0;

    // Two full passes from a clean reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("seq_reset_state", 64'({s_ready_x, s_ready_f, conv_start, busy, pass_cnt}),
          64'({1'b1, 1'b1, 1'b0, 1'b0, 16'd0}));
    step();

    run_pass(lat, xs, fs, f_rdy_seen);
    check("p1_start_latency", 64'(lat), 64'(9));
    check("p1_x_beats", 64'(xs), 64'(8));
    check("p1_f_beats", 64'(fs), 64'(4));

    pulse_done();
    @(negedge clk);
    check("p1_flush", 64'({conv_start, busy, s_ready_x, s_ready_f}), 64'(4'b0100));
    step();
    @(negedge clk);
    check("p1_reaccept", 64'({s_ready_x, s_ready_f, busy}), 64'({1'b1, !Reuse, 1'b0}));
    check("p1_pass_cnt", 64'(pass_cnt), 64'(1));
    step();

    run_pass(lat, xs, fs, f_rdy_seen);
    check("p2_start_latency", 64'(lat), 64'(9));
    check("p2_x_beats", 64'(xs), 64'(8));
    check("p2_f_beats", 64'(fs), 64'(Reuse ? 0 : 4));
    check("p2_f_ready_seen", 64'(f_rdy_seen), 64'(!Reuse));

    pulse_done();
    @(negedge clk);
    check("p2_flush_pass_cnt", 64'({conv_start, busy, pass_cnt}), 64'({1'b0, 1'b1, 16'd2}));
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_load_sequencer.md
Name: conv_load_sequencer

Overview:
- Top-level sequencer for the convolution engine.
- Accepts filter and input vectors over two AXI-stream-style slave ports.
- Generates write enables, addresses and data for the F and X memories.
- Holds conv_start high while the output controller runs a pass, then recycles the memories for the next vector on the conv_done pulse.

Parameters:
- DATA_W, 8: width of one sample.
- X_MEM_SIZE, 8: X samples per vector.
- F_MEM_SIZE, 4: filter taps.
- X_MEM_ADDR_WIDTH, 3: X memory address width, equal to $clog2(X_MEM_SIZE).
- F_MEM_ADDR_WIDTH, 2: F memory address width, equal to $clog2(F_MEM_SIZE).
- CNT_W, 16: width of the completed-pass counter.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- s_data_in_x  in  DATA_W  X stream data.
- s_valid_x  in  1  X stream valid.
- s_ready_x  out  1  X stream ready.
- s_data_in_f  in  DATA_W  F stream data.
- s_valid_f  in  1  F stream valid.
- s_ready_f  out  1  F stream ready.
- wr_en_x  out  1  X memory write enable.
- wr_addr_x  out  X_MEM_ADDR_WIDTH  X memory write address.
- wr_data_x  out  DATA_W  X memory write data.
- wr_en_f  out  1  F memory write enable.
- wr_addr_f  out  F_MEM_ADDR_WIDTH  F memory write address.
- wr_data_f  out  DATA_W  F memory write data.
- conv_done  in  1  one-cycle pulse from the output controller: pass finished.
- conv_start  out  1  level; high for the whole pass.
- busy  out  1  high in CONV and FLUSH.
- pass_cnt  out  CNT_W  number of completed passes.

Behaviour:
- States: LOAD, CONV, FLUSH. Encoded state register.
- Reset: all of the following take effect at the clock edge where reset is sampled high, including mid-pass.
  - state=LOAD.
  - x_cnt=0, f_cnt=0, x_full=0, f_full=0.
  - conv_start=0, pass_cnt=0.
  - busy=0, s_ready_x=0 and s_ready_f=0 during the reset cycle.
- Ready signals:
  - s_ready_x = (state==LOAD) && !x_full.
  - s_ready_f = (state==LOAD) && !f_full.
  - Both are combinational from registers only, with no dependence on valid.
- X transfer: s_valid_x && s_ready_x.
  - Same cycle, combinational: wr_en_x=1, wr_addr_x=x_cnt, wr_data_x=s_data_in_x.
  - Next edge: x_cnt increments.
  - At x_cnt==X_MEM_SIZE-1 the counter wraps to 0 and x_full is set.
- F transfer: same rules using f_cnt, F_MEM_SIZE and f_full.
- X and F load concurrently and independently. Either stream may complete first. A stalled stream does not block the other.
- wr_en_x and wr_en_f are 0 outside transfer cycles. Address and data are don't-care then but are driven with the counter value and the input data.
- LOAD -> CONV: on the edge where x_full && f_full are both already set.
  - conv_start goes 1 on that same edge, registered.
  - First CONV cycle = the cycle after the last beat was written, so the memories are stable.
- CONV:
  - conv_start=1, busy=1, both readies 0.
  - Waits indefinitely for conv_done. No timeout.
- CONV -> FLUSH on conv_done=1. At that edge:
  - conv_start <= 0.
  - pass_cnt increments, saturating at all-ones.
  - x_full is cleared.
  - f_full is cleared, unless the optional feature keeps it.
- FLUSH: exactly one cycle with conv_start=0, busy=1, readies 0. This lets the output controller clear its accumulator and pass tracker. Then the FSM goes to LOAD.
- conv_done sampled in LOAD or FLUSH is ignored: no state change and no counter change.
- Earliest re-accept: s_ready is high 2 cycles after the conv_done edge.
- Back-to-back beats: one beat per cycle per stream sustained, with no bubbles.

Optional Feature:
- Macro: FILTER_REUSE_EN.
- Defined:
  - f_full is set on the first complete filter load and is cleared only by reset.
  - Later passes reload X only, so s_ready_f stays 0 after the first load.
  - LOAD -> CONV requires x_full only once f_full is held.
- Not defined: F is reloaded for every pass, as described under Behaviour.

Test Plan (defaults X_MEM_SIZE=8, F_MEM_SIZE=4):
- Reset, then stream F=1,2,3,4 and X=10..17 with valid held high and conv_done tied low.
  - Expect 4 wr_en_f pulses at addresses 0..3 and 8 wr_en_x pulses at addresses 0..7.
  - Expect conv_start=1 at cycle 9 after the first beat.
  - Expect both readies 0 after that.
- Stall X after 3 beats while F completes.
  - Expect s_ready_f=0 after 4 beats.
  - Expect s_ready_x to stay 1, conv_start=0 and wr_addr_x resuming at 3.
- In CONV, pulse conv_done for 1 cycle.
  - Expect conv_start=0 on the next cycle and a FLUSH cycle with busy=1.
  - Expect s_ready_x=s_ready_f=1 2 cycles after the pulse and pass_cnt=1.
- Pulse conv_done during LOAD.
  - Expect no state change, pass_cnt unchanged and readies unaffected.
- Assert reset for 1 cycle mid-CONV.
  - Expect conv_start=0, pass_cnt=0, state LOAD with both readies 1 on the cycle after reset deasserts.
  - Expect reload addresses to start at 0.
- With FILTER_REUSE_EN, run two passes.
  - Expect the second pass to accept 8 X beats, keep s_ready_f=0 throughout, and raise conv_start after X alone.
  - Expect pass_cnt=2.
